raiz_arbiter: RTL and testbench

Shares one square-root core (16-bit radicand, 8-bit root, init/done handshake) between N requesters. Round-robin arbitration; each winner gets one launch of the core. The block also sequences the core's reset/init pins and aborts hung operations with a watchdog. It sits between the requesting datapaths and the single raiz core instance.

---
 rtl/raiz_pkg.sv | 21 ++
 rtl/raiz_arbiter_if.sv | 56 +++++
 rtl/rr_picker.sv | 34 +++
 rtl/raiz_arbiter.sv | 145 ++++++++++++++
 tb/tb_raiz_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/raiz_pkg.sv
// Shared types and helpers for the square-root core arbiter.
// Holds the FSM state encoding, default widths and the watchdog counter sizing.
package raiz_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    ABORT  = 3'd4
  } state_e;

  localparam int OPW_DEF  = 16;
  localparam int RESW_DEF = 8;

  // Bits needed to hold the values 0..timeout inclusive.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/raiz_arbiter_if.sv
// Requester-side and core-side signal bundle of the square-root core arbiter.
// master = the arbiter itself, slave = requesters plus the raiz core.
interface raiz_arbiter_if
  import raiz_pkg::*;
#(
  parameter int N    = 4,
  parameter int OPW  = OPW_DEF,
  parameter int RESW = RESW_DEF
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     in_req;
  logic [N*OPW-1:0] in_operand;
  logic [N-1:0]     out_ack;
  logic [RESW-1:0]  out_result;
  logic             out_err;
  logic             out_busy;
  logic [GW-1:0]    out_grant_id;
  logic             out_core_init;
  logic             out_core_rst;
  logic [OPW-1:0]   out_core_operand;
  logic             in_core_done;
  logic [RESW-1:0]  in_core_result;

  modport master (
    input  in_req,
    input  in_operand,
    input  in_core_done,
    input  in_core_result,
    output out_ack,
    output out_result,
    output out_err,
    output out_busy,
    output out_grant_id,
    output out_core_init,
    output out_core_rst,
    output out_core_operand
  );

  modport slave (
    output in_req,
    output in_operand,
    output in_core_done,
    output in_core_result,
    input  out_ack,
    input  out_result,
    input  out_err,
    input  out_busy,
    input  out_grant_id,
    input  out_core_init,
    input  out_core_rst,
    input  out_core_operand
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request bit scanning upward
// from ptr, wrapping modulo N.
module rr_picker #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] index
);

  // cand[k] is the requester examined k-th in the rotated scan order.
  logic [PW-1:0] cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = PW'((32'(ptr) + 32'(gi)) % 32'(N));
    end
  endgenerate

  // Scan from the far end so the nearest set bit overwrites the others.
  always_comb begin
    valid = |req;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        index = cand[k];
      end
    end
  end

endmodule

// File: rtl/raiz_arbiter.sv
// Round-robin sharing of one square-root core among N requesters, with core
// reset/init sequencing and a watchdog that aborts a hung core operation.
module raiz_arbiter
  import raiz_pkg::*;
#(
  parameter int N       = 4,
  parameter int OPW     = OPW_DEF,
  parameter int RESW    = RESW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  raiz_arbiter_if.master bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = cnt_width(TIMEOUT);

  state_e          state_reg, state_next;
  logic [GW-1:0]   ptr_reg, ptr_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [OPW-1:0]  operand_reg, operand_next;
  logic [CW-1:0]   counter_reg, counter_next;
  logic [RESW-1:0] result_reg, result_next;
  logic            err_reg, err_next;

  logic            pick_valid;
  logic [GW-1:0]   pick_idx;

  logic [N-1:0]    ack;
  logic            core_init;
  logic            core_rst;
  logic            busy;

  rr_picker #(
    .N (N)
  ) u_picker (
    .req   (bus.in_req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      grant_reg   <= '0;
      operand_reg <= '0;
      counter_reg <= '0;
      result_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      grant_reg   <= grant_next;
      operand_reg <= operand_next;
      counter_reg <= counter_next;
      result_reg  <= result_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    grant_next   = grant_reg;
    operand_next = operand_reg;
    counter_next = counter_reg;
    result_next  = result_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next   = pick_idx;
          operand_next = bus.in_operand[int'(pick_idx)*OPW +: OPW];
          state_next   = LAUNCH;
        end
      end
      LAUNCH: begin
        counter_next = CW'(TIMEOUT);
        state_next   = WAIT;
      end
      WAIT: begin
        // A done arriving on the last watchdog cycle still counts as success.
        if (bus.in_core_done) begin
          result_next = bus.in_core_result;
          err_next    = 1'b0;
          state_next  = RESP;
        end else if (counter_reg == '0) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = ABORT;
        end else begin
          counter_next = counter_reg - 1'b1;
        end
      end
      RESP, ABORT: begin
        ptr_next   = (grant_reg == GW'(N - 1)) ? '0 : grant_reg + 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Core is held in reset whenever no operation is launched or pending.
  always_comb begin
    ack       = '0;
    core_init = 1'b0;
    core_rst  = 1'b1;
    busy      = 1'b1;

    case (state_reg)
      IDLE: begin
        busy = 1'b0;
      end
      LAUNCH: begin
        core_rst  = 1'b0;
        core_init = 1'b1;
      end
      WAIT: begin
        core_rst = 1'b0;
      end
      RESP, ABORT: begin
        ack[grant_reg] = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign bus.out_ack          = ack;
  assign bus.out_result       = result_reg;
  assign bus.out_err          = err_reg;
  assign bus.out_busy         = busy;
  assign bus.out_grant_id     = grant_reg;
  assign bus.out_core_init    = core_init;
  assign bus.out_core_rst     = core_rst;
  assign bus.out_core_operand = operand_reg;

endmodule

// File: tb/tb_raiz_arbiter.sv
// Scoreboard bench for raiz_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares each ack the arbiter presents.
module tb_raiz_arbiter;
  import raiz_pkg::*;

  localparam int N       = 4;
  localparam int OPW     = 16;
  localparam int RESW    = 8;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  raiz_arbiter_if #(.N(N), .OPW(OPW), .RESW(RESW)) bus ();

  raiz_arbiter #(
    .N       (N),
    .OPW     (OPW),
    .RESW    (RESW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int id;
    int result;
    int err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic expect_ack(input int id, input int result, input int err);
    exp_t e;
    e.id     = id;
    e.result = result;
    e.err    = err;
    exp_q.push_back(e);
  endtask

  function automatic int id_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Behavioural square-root core: result appears lat_cfg cycles after init.
  int        lat_cfg      = LAT;
  int        core_cnt     = 0;
  logic      model_done   = 1'b0;
  logic [7:0] model_result = '0;
  logic      stray_done   = 1'b0;

  function automatic logic [7:0] isqrt(input logic [15:0] v);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return 8'(r);
  endfunction

  always @(posedge clk) begin
    if (bus.out_core_rst === 1'b1) begin
      core_cnt   <= 0;
      model_done <= 1'b0;
    end else if (bus.out_core_init === 1'b1) begin
      core_cnt     <= lat_cfg;
      model_done   <= 1'b0;
      model_result <= isqrt(bus.out_core_operand);
    end else if (core_cnt != 0) begin
      model_done <= (core_cnt == 1);
      core_cnt   <= core_cnt - 1;
    end else begin
      model_done <= 1'b0;
    end
  end

  assign bus.in_core_done   = model_done | stray_done;
  assign bus.in_core_result = model_result;

  // Monitor: every ack is matched against the head of the expectation queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_ack !== '0) begin
      check("ack_onehot", 32'($onehot(bus.out_ack)), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(bus.out_ack), 0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("ack id=%0d result=%0d err=%0d", id_of(bus.out_ack), bus.out_result, bus.out_err);
        check("ack_id", id_of(bus.out_ack), mon_e.id);
        check("ack_grant_id", 32'(bus.out_grant_id), mon_e.id);
        check("ack_result", 32'(bus.out_result), mon_e.result);
        check("ack_err", 32'(bus.out_err), mon_e.err);
        check("ack_core_rst", 32'(bus.out_core_rst), 1);
        check("ack_busy", 32'(bus.out_busy), 1);
      end
    end
  end

  task automatic set_op(input int i, input int v);
    bus.in_operand[i*OPW +: OPW] = 16'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    bus.in_req = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(bus.out_ack), 0);
    check("rst_err", 32'(bus.out_err), 0);
    check("rst_busy", 32'(bus.out_busy), 0);
    check("rst_core_init", 32'(bus.out_core_init), 0);
    check("rst_core_rst", 32'(bus.out_core_rst), 1);
    check("rst_grant_id", 32'(bus.out_grant_id), 0);
    check("rst_result", 32'(bus.out_result), 0);
    check("rst_core_operand", 32'(bus.out_core_operand), 0);
    rst = 1'b1;
  endtask

  task automatic wait_acks(input int n, input int budget, output int cycles);
    int got = 0;
    cycles = 0;
    while (got < n && cycles < budget) begin
      @(negedge clk);
      cycles++;
      for (int i = 0; i < N; i++) begin
        if (bus.out_ack[i] === 1'b1) begin
          bus.in_req[i] = 1'b0;
          got++;
        end
      end
    end
    check("acks_seen", got, n);
  endtask

  task automatic wait_init(input int budget);
    int c = 0;
    while (bus.out_core_init !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("init_seen", 32'(bus.out_core_init), 1);
  endtask

  initial begin
    bus.in_req     = '0;
    bus.in_operand = '0;

    do_reset();

    // Single request, operand 144.
    set_op(0, 144);
    expect_ack(0, 12, 0);
    bus.in_req = 4'b0001;
    @(negedge clk);
    check("launch_init", 32'(bus.out_core_init), 1);
    check("launch_core_rst", 32'(bus.out_core_rst), 0);
    check("launch_busy", 32'(bus.out_busy), 1);
    check("launch_operand", 32'(bus.out_core_operand), 144);
    @(negedge clk);
    check("init_one_cycle", 32'(bus.out_core_init), 0);
    wait_acks(1, 200, cyc);
    check("single_latency", cyc, LAT + 1);
    @(negedge clk);
    check("idle_busy", 32'(bus.out_busy), 0);
    check("result_hold", 32'(bus.out_result), 12);

    // All four requesting together from ptr 0.
    do_reset();
    set_op(0, 0);
    set_op(1, 1);
    set_op(2, 255);
    set_op(3, 65535);
    expect_ack(0, 0, 0);
    expect_ack(1, 1, 0);
    expect_ack(2, 15, 0);
    expect_ack(3, 255, 0);
    bus.in_req = 4'b1111;
    wait_acks(4, 400, cyc);

    // Pointer: after requester 1, 3 outranks 0.
    set_op(1, 4);
    expect_ack(1, 2, 0);
    bus.in_req = 4'b0010;
    wait_acks(1, 200, cyc);
    set_op(3, 9);
    set_op(0, 16);
    expect_ack(3, 3, 0);
    expect_ack(0, 4, 0);
    bus.in_req = bus.in_req | 4'b1001;
    wait_acks(2, 300, cyc);

    // Operand changed after grant is ignored.
    set_op(2, 100);
    expect_ack(2, 10, 0);
    bus.in_req = 4'b0100;
    wait_init(10);
    set_op(2, 225);
    @(negedge clk);
    check("latched_operand", 32'(bus.out_core_operand), 100);
    wait_acks(1, 200, cyc);

    // Stray done while idle.
    @(negedge clk);
    stray_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_ack", 32'(bus.out_ack), 0);
      check("stray_busy", 32'(bus.out_busy), 0);
    end
    stray_done = 1'b0;

    // Watchdog abort with a stuck core.
    lat_cfg = 0;
    set_op(0, 49);
    expect_ack(0, 0, 1);
    bus.in_req = 4'b0001;
    wait_init(10);
    wait_acks(1, 200, cyc);
    check("watchdog_latency", cyc, TIMEOUT + 2);
    @(negedge clk);
    check("err_hold", 32'(bus.out_err), 1);
    lat_cfg = LAT;
    set_op(1, 25);
    set_op(0, 36);
    expect_ack(1, 5, 0);
    expect_ack(0, 6, 0);
    bus.in_req = 4'b0011;
    wait_acks(2, 300, cyc);

    // Done on the very cycle the watchdog expires.
    lat_cfg = TIMEOUT;
    set_op(1, 81);
    expect_ack(1, 9, 0);
    bus.in_req = 4'b0010;
    wait_init(10);
    wait_acks(1, 200, cyc);
    check("coincide_latency", cyc, TIMEOUT + 2);

    // Reset in the middle of WAIT abandons the transaction.
    lat_cfg = 0;
    set_op(3, 64);
    bus.in_req = 4'b1000;
    wait_init(10);
    repeat (5) @(negedge clk);
    rst        = 1'b0;
    bus.in_req = '0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_ack", 32'(bus.out_ack), 0);
    check("midrst_busy", 32'(bus.out_busy), 0);
    check("midrst_core_rst", 32'(bus.out_core_rst), 1);
    check("midrst_grant_id", 32'(bus.out_grant_id), 0);
    repeat (3) @(negedge clk);
    check("midrst_quiet", 32'(bus.out_busy), 0);
    lat_cfg = LAT;
    set_op(0, 121);
    set_op(2, 169);
    expect_ack(0, 11, 0);
    expect_ack(2, 13, 0);
    bus.in_req = 4'b0101;
    wait_acks(2, 300, cyc);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
